// File: rtl/stage_modify_fold_pkg.sv
// ---------------------------------------------------------------------------
// stage_modify_fold_pkg
//
// Shared definitions for the BF CPU modify stage with INC/DEC folding:
//   - one-hot opcode bus width and bit positions (same layout as the other
//     pipeline stages),
//   - fold FSM state encoding (FOLD_IDLE / FOLD_ACCUM),
//   - small opcode classification helpers.
// ---------------------------------------------------------------------------
package stage_modify_fold_pkg;

  // Highest bit of the one-hot opcode bus.
  localparam int OPCODE_MSB = 7;

  // Bit positions inside the one-hot opcode bus.
  typedef enum int unsigned {
    OP_INC   = 0,  // "+"
    OP_DEC   = 1,  // "-"
    OP_RIGHT = 2,  // ">"
    OP_LEFT  = 3,  // "<"
    OP_OUT   = 4,  // "."
    OP_IN    = 5,  // ","
    OP_JZ    = 6,  // "["
    OP_JNZ   = 7   // "]"
  } op_bit_e;

  typedef logic [OPCODE_MSB:0] opcode_t;

  // Fold FSM states.
  typedef enum logic {
    FOLD_IDLE  = 1'b0,
    FOLD_ACCUM = 1'b1
  } fold_state_e;

  // INC and DEC are the only ops that can be merged into one cell write.
  function automatic logic is_fold(input opcode_t op);
    return op[OP_INC] | op[OP_DEC];
  endfunction

  // IN and OUT carry a data byte downstream; every other pass-through op
  // presents a zero data word.
  function automatic logic carries_data(input opcode_t op);
    return op[OP_IN] | op[OP_OUT];
  endfunction

endpackage

// File: rtl/stage_modify_step.sv
// ---------------------------------------------------------------------------
// stage_modify_step
//
// Combinational single-step cell update: stepped = val + 1 or val - 1.
//
// Build option:
//   STAGE_MODIFY_SATURATE_EN  defined   -> each step clamps at 0 / 2^D_WIDTH-1
//                             undefined -> modular wrap (no clamp logic built)
//
// Ports:
//   val      in  D_WIDTH  value before the step
//   dec      in  1        1 = decrement, 0 = increment
//   stepped  out D_WIDTH  value after the step
// ---------------------------------------------------------------------------
module stage_modify_step #(
  parameter int D_WIDTH = 8
) (
  input  logic [D_WIDTH-1:0] val,
  input  logic               dec,
  output logic [D_WIDTH-1:0] stepped
);

`ifdef STAGE_MODIFY_SATURATE_EN
  localparam logic [D_WIDTH-1:0] MAX_VAL = '1;

  // Clamp is applied to this single step only; a run like "+","-" from the
  // maximum therefore ends one below the maximum.
  always_comb begin
    if (dec) begin
      stepped = (val == '0) ? val : val - D_WIDTH'(1);
    end else begin
      stepped = (val == MAX_VAL) ? val : val + D_WIDTH'(1);
    end
  end
`else
  // Plain modulo-2^D_WIDTH arithmetic: 255+1 -> 0, 0-1 -> 255.
  assign stepped = dec ? val - D_WIDTH'(1) : val + D_WIDTH'(1);
`endif

endmodule

// File: rtl/stage_modify_fold.sv
// ---------------------------------------------------------------------------
// stage_modify_fold
//
// Cell-modify pipeline stage of the BF CPU. Sits between the cell-read and
// write-back stages. Consecutive INC/DEC ops are folded into a single output
// carrying the net cell value, so a run of N "+"/"-" costs one downstream
// write. Every other op passes through with one cycle of latency.
//
// Build option (handled in stage_modify_step):
//   STAGE_MODIFY_SATURATE_EN  saturating per-step arithmetic instead of wrap.
//
// Parameters:
//   D_WIDTH    cell/data width
//   MAX_RUN    max source ops folded into one output (1..255, 1 = no folding)
//   RUN_WIDTH  width of the run counter and run_len (derived)
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-low reset
//   a_in          in   cell value (or input byte for IN) with operation_in
//   operation_in  in   one-hot op from upstream
//   drdy_in       in   upstream op valid
//   ack           out  upstream op consumed this cycle (combinational)
//   a             out  value to write back / output
//   operation     out  op presented downstream (first op of a folded run)
//   drdy          out  downstream output valid
//   ack_in        in   downstream accepts the output
//   run_len       out  number of source ops folded into the current output
// ---------------------------------------------------------------------------
module stage_modify_fold
  import stage_modify_fold_pkg::*;
#(
  parameter  int D_WIDTH   = 8,
  parameter  int MAX_RUN   = 16,
  localparam int RUN_WIDTH = $clog2(MAX_RUN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [D_WIDTH-1:0]   a_in,
  input  logic [OPCODE_MSB:0]  operation_in,
  input  logic                 drdy_in,
  output logic                 ack,
  output logic [D_WIDTH-1:0]   a,
  output logic [OPCODE_MSB:0]  operation,
  output logic                 drdy,
  input  logic                 ack_in,
  output logic [RUN_WIDTH-1:0] run_len
);

  localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(MAX_RUN);
  localparam logic [RUN_WIDTH-1:0] RUN_ONE = RUN_WIDTH'(1);
  // With MAX_RUN == 1 a fold op is emitted straight from IDLE.
  localparam bit NO_FOLD = (MAX_RUN == 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  fold_state_e          state;
  logic [D_WIDTH-1:0]   val;   // running cell value of the open run
  logic [RUN_WIDTH-1:0] run;   // ops folded so far in the open run
  opcode_t              op0;   // first op of the open run

  // -------------------------------------------------------------------------
  // Datapath / control
  // -------------------------------------------------------------------------
  logic                 fold;
  logic                 free;
  logic                 take;
  logic                 run_full;
  logic                 emit;
  logic                 load;
  opcode_t              load_op;
  logic [D_WIDTH-1:0]   load_a;
  logic [RUN_WIDTH-1:0] load_len;
  logic [D_WIDTH-1:0]   step_base;
  logic [D_WIDTH-1:0]   stepped;

  // The first op of a run steps from the cell value it carries; later ops
  // step from the accumulated value.
  assign step_base = (state == FOLD_ACCUM) ? val : a_in;

  stage_modify_step #(
    .D_WIDTH (D_WIDTH)
  ) u_step (
    .val     (step_base),
    .dec     (operation_in[OP_DEC]),
    .stepped (stepped)
  );

  assign fold     = is_fold(operation_in);
  assign free     = !drdy | ack_in;
  assign run_full = (run == RUN_MAX);
  assign take     = drdy_in & ack;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    ack      = 1'b0;
    emit     = 1'b0;
    load     = 1'b0;
    load_op  = operation_in;
    load_a   = '0;
    load_len = RUN_ONE;

    case (state)
      FOLD_IDLE: begin
        ack = free;
        if (drdy_in && free) begin
          if (!fold) begin
            load   = 1'b1;
            load_a = carries_data(operation_in) ? a_in : '0;
          end else if (NO_FOLD) begin
            load   = 1'b1;
            load_a = stepped;
          end
        end
      end

      FOLD_ACCUM: begin
        // Keep absorbing while the next op is a fold op and the run has room.
        ack  = drdy_in & fold & !run_full;
        // A bubble, a non-fold op or a full run closes the run. The breaking
        // op itself is left on the input for IDLE to consume later.
        emit = free & (!drdy_in | !fold | run_full);
        if (emit) begin
          load     = 1'b1;
          load_op  = op0;
          load_a   = val;
          load_len = run;
        end
      end

      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers: FSM, run accumulator and output slot
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the run accumulator is reset along with the output slot, so a
      // partial fold interrupted by reset can never reappear afterwards.
      state     <= FOLD_IDLE;
      val       <= '0;
      run       <= '0;
      op0       <= '0;
      drdy      <= 1'b0;
      operation <= '0;
      a         <= '0;
      run_len   <= '0;
    end else begin
      // Output slot: load, otherwise drop the valid once it is accepted.
      if (load) begin
        operation <= load_op;
        a         <= load_a;
        run_len   <= load_len;
        drdy      <= 1'b1;
      end else if (ack_in) begin
        drdy      <= 1'b0;
      end

      case (state)
        FOLD_IDLE: begin
          if (take && fold && !NO_FOLD) begin
            val   <= stepped;
            run   <= RUN_ONE;
            op0   <= operation_in;
            state <= FOLD_ACCUM;
          end
        end

        FOLD_ACCUM: begin
          if (take) begin
            val <= stepped;
            run <= run + RUN_ONE;
          end else if (emit) begin
            state <= FOLD_IDLE;
          end
        end

        default: state <= FOLD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_modify_fold.sv
// ---------------------------------------------------------------------------
// tb_stage_modify_fold
//
// Two instances: unit 0 with MAX_RUN=16, unit 1 with MAX_RUN=4. Directed
// scenarios plus randomized op streams checked against a run-grouping model.
// ---------------------------------------------------------------------------
module tb_stage_modify_fold;
  import stage_modify_fold_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] a_in    [2];
  opcode_t    op_in   [2];
  logic       drdy_in [2];
  logic       ack_in  [2];
  logic       ack     [2];
  logic [7:0] a_out   [2];
  opcode_t    op_out  [2];
  logic       drdy    [2];
  logic [4:0] rl16;
  logic [2:0] rl4;

  stage_modify_fold #(.D_WIDTH(8), .MAX_RUN(16)) dut (
    .clk(clk), .reset(reset), .a_in(a_in[0]), .operation_in(op_in[0]),
    .drdy_in(drdy_in[0]), .ack(ack[0]), .a(a_out[0]), .operation(op_out[0]),
    .drdy(drdy[0]), .ack_in(ack_in[0]), .run_len(rl16)
  );

  stage_modify_fold #(.D_WIDTH(8), .MAX_RUN(4)) dut4 (
    .clk(clk), .reset(reset), .a_in(a_in[1]), .operation_in(op_in[1]),
    .drdy_in(drdy_in[1]), .ack(ack[1]), .a(a_out[1]), .operation(op_out[1]),
    .drdy(drdy[1]), .ack_in(ack_in[1]), .run_len(rl4)
  );

  typedef struct { opcode_t op; logic [7:0] a; int rl; } out_t;
  typedef struct { opcode_t op; logic [7:0] a; int gap; } src_t;

  out_t obs0[$];
  out_t obs1[$];
  out_t exp_q[$];
  src_t src_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Output monitor: a transfer happens on the edge after drdy & ack_in.
  always @(negedge clk) begin
    if (reset && drdy[0] && ack_in[0]) obs0.push_back('{op_out[0], a_out[0], int'(rl16)});
    if (reset && drdy[1] && ack_in[1]) obs1.push_back('{op_out[1], a_out[1], int'(rl4)});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  function automatic opcode_t oh(input int b);
    return opcode_t'(1) << b;
  endfunction

  function automatic int rl_of(input int u);
    return (u == 0) ? int'(rl16) : int'(rl4);
  endfunction

  // Reference single step of the cell value.
  function automatic logic [7:0] step_ref(input logic [7:0] v, input bit dec);
`ifdef STAGE_MODIFY_SATURATE_EN
    if (dec) return (v == 8'h00) ? v : v - 8'd1;
    return (v == 8'hFF) ? v : v + 8'd1;
`else
    return dec ? v - 8'd1 : v + 8'd1;
`endif
  endfunction

  // Expected outputs for src_q with the output always accepted: fold ops
  // presented without a gap form one group, split every max_run ops; every
  // other op is its own output.
  task automatic build_expect(input int max_run);
    out_t cur;
    bit   open = 1'b0;
    exp_q.delete();
    cur = '{'0, 8'h00, 0};
    foreach (src_q[k]) begin
      bit f;
      f = src_q[k].op[OP_INC] | src_q[k].op[OP_DEC];
      if (open && (src_q[k].gap > 0 || !f || cur.rl == max_run)) begin
        exp_q.push_back(cur);
        open = 1'b0;
      end
      if (f) begin
        if (!open) begin
          cur  = '{src_q[k].op, src_q[k].a, 0};
          open = 1'b1;
        end
        cur.a  = step_ref(cur.a, src_q[k].op[OP_DEC]);
        cur.rl = cur.rl + 1;
      end else begin
        exp_q.push_back('{src_q[k].op,
                          (src_q[k].op[OP_IN] | src_q[k].op[OP_OUT]) ? src_q[k].a : 8'h00, 1});
      end
    end
    if (open) exp_q.push_back(cur);
  endtask

  // ---- stimulus helpers (all leave time at posedge + 1) ----
  task automatic present(input int u, input opcode_t op, input logic [7:0] a);
    op_in[u]   = op;
    a_in[u]    = a;
    drdy_in[u] = 1'b1;
  endtask

  task automatic idle(input int u);
    drdy_in[u] = 1'b0;
    op_in[u]   = '0;
    a_in[u]    = '0;
  endtask

  task automatic wait_take(input int u, input string name);
    bit got = 1'b0;
    int cyc = 0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      if (ack[u]) got = 1'b1;
      else cyc++;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: ack stayed %0b for 64 cycles, required 1", name, ack[u]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b0;
    #2;
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if (drdy[u] !== 1'b0) begin n_bad++; $display("FAIL reset_drdy u%0d: got %0b want 0", u, drdy[u]); end
      n_cmp++;
      if (a_out[u] !== 8'h00) begin n_bad++; $display("FAIL reset_a u%0d: got %h want 00", u, a_out[u]); end
      n_cmp++;
      if (op_out[u] !== 8'h00) begin n_bad++; $display("FAIL reset_op u%0d: got %h want 00", u, op_out[u]); end
      n_cmp++;
      if (rl_of(u) !== 0) begin n_bad++; $display("FAIL reset_run_len u%0d: got %0d want 0", u, rl_of(u)); end
      n_cmp++;
      if (ack[u] !== 1'b1) begin n_bad++; $display("FAIL reset_ack u%0d: got %0b want 1", u, ack[u]); end
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pass_through();
    present(0, oh(OP_OUT), 8'h41);
    wait_take(0, "pt_out_take");
    n_cmp++;
    if (drdy[0] !== 1'b1 || op_out[0] !== oh(OP_OUT) || a_out[0] !== 8'h41 || rl16 !== 5'd1) begin
      n_bad++;
      $display("FAIL pt_out: got drdy=%0b op=%h a=%h len=%0d want 1/%h/41/1",
               drdy[0], op_out[0], a_out[0], rl16, oh(OP_OUT));
    end
    present(0, oh(OP_LEFT), 8'h77);
    wait_take(0, "pt_left_take");
    n_cmp++;
    if (drdy[0] !== 1'b1 || op_out[0] !== oh(OP_LEFT) || a_out[0] !== 8'h00 || rl16 !== 5'd1) begin
      n_bad++;
      $display("FAIL pt_left: got drdy=%0b op=%h a=%h len=%0d want 1/%h/00/1",
               drdy[0], op_out[0], a_out[0], rl16, oh(OP_LEFT));
    end
    idle(0);
    cycles(2);
    n_cmp++;
    if (drdy[0] !== 1'b0) begin n_bad++; $display("FAIL pt_drain: drdy got %0b want 0", drdy[0]); end
  endtask

  task automatic test_fold();
    logic [7:0] start_v [2];
    logic [7:0] want_v  [2];
    opcode_t    ops     [2];
    start_v = '{8'hFE, 8'h02};
    ops     = '{oh(OP_INC), oh(OP_DEC)};
`ifdef STAGE_MODIFY_SATURATE_EN
    want_v = '{8'hFF, 8'h00};
`else
    want_v = '{8'h03, 8'hFD};
`endif
    for (int c = 0; c < 2; c++) begin
      obs0.delete();
      present(0, ops[c], start_v[c]);
      wait_take(0, "fold_take");
      for (int k = 1; k < 5; k++) begin
        present(0, ops[c], 8'($urandom));
        wait_take(0, "fold_take");
      end
      idle(0);
      cycles(3);
      n_cmp++;
      if (obs0.size() != 1) begin
        n_bad++;
        $display("FAIL fold%0d_count: got %0d outputs want 1", c, obs0.size());
      end else begin
        n_cmp++;
        if (obs0[0].op !== ops[c] || obs0[0].a !== want_v[c] || obs0[0].rl != 5) begin
          n_bad++;
          $display("FAIL fold%0d: got op=%h a=%h len=%0d want %h/%h/5",
                   c, obs0[0].op, obs0[0].a, obs0[0].rl, ops[c], want_v[c]);
        end
      end
    end
  endtask

  task automatic test_bubble();
    present(0, oh(OP_INC), 8'h10);
    wait_take(0, "bubble_take");
    present(0, oh(OP_INC), 8'h99);
    wait_take(0, "bubble_take");
    idle(0);
    n_cmp++;
    if (drdy[0] !== 1'b0) begin n_bad++; $display("FAIL bubble_early: drdy got %0b want 0", drdy[0]); end
    cycles(1);
    n_cmp++;
    if (drdy[0] !== 1'b1 || op_out[0] !== oh(OP_INC) || a_out[0] !== 8'h12 || rl16 !== 5'd2) begin
      n_bad++;
      $display("FAIL bubble_flush: got drdy=%0b op=%h a=%h len=%0d want 1/%h/12/2",
               drdy[0], op_out[0], a_out[0], rl16, oh(OP_INC));
    end
    cycles(2);
  endtask

  task automatic test_run_limit();
    out_t want [2];
    want = '{'{oh(OP_DEC), 8'd6, 4}, '{oh(OP_DEC), 8'd8, 2}};
    obs1.delete();
    for (int k = 0; k < 6; k++) begin
      present(1, oh(OP_DEC), 8'd10);
      wait_take(1, "limit_take");
    end
    idle(1);
    cycles(4);
    n_cmp++;
    if (obs1.size() != 2) begin
      n_bad++;
      $display("FAIL limit_count: got %0d outputs want 2", obs1.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs1[k].op !== want[k].op || obs1[k].a !== want[k].a || obs1[k].rl != want[k].rl) begin
          n_bad++;
          $display("FAIL limit_out%0d: got op=%h a=%0d len=%0d want %h/%0d/%0d",
                   k, obs1[k].op, obs1[k].a, obs1[k].rl, want[k].op, want[k].a, want[k].rl);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit   acked = 1'b0;
    out_t want [2];
    want = '{'{oh(OP_INC), 8'h23, 3}, '{oh(OP_OUT), 8'h55, 1}};
    obs0.delete();
    ack_in[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      present(0, oh(OP_INC), 8'h20);
      wait_take(0, "bp_take");
    end
    present(0, oh(OP_OUT), 8'h55);
    repeat (4) begin
      @(negedge clk);
      if (ack[0] !== 1'b0) acked = 1'b1;
    end
    n_cmp++;
    if (acked) begin n_bad++; $display("FAIL bp_hold_ack: OUT acked during backpressure, want ack=0"); end
    n_cmp++;
    if (drdy[0] !== 1'b1 || op_out[0] !== oh(OP_INC) || a_out[0] !== 8'h23 || rl16 !== 5'd3) begin
      n_bad++;
      $display("FAIL bp_hold_out: got drdy=%0b op=%h a=%h len=%0d want 1/%h/23/3",
               drdy[0], op_out[0], a_out[0], rl16, oh(OP_INC));
    end
    @(posedge clk);
    #1;
    ack_in[0] = 1'b1;
    wait_take(0, "bp_out_take");
    idle(0);
    cycles(4);
    n_cmp++;
    if (obs0.size() != 2) begin
      n_bad++;
      $display("FAIL bp_count: got %0d outputs want 2", obs0.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs0[k].op !== want[k].op || obs0[k].a !== want[k].a || obs0[k].rl != want[k].rl) begin
          n_bad++;
          $display("FAIL bp_out%0d: got op=%h a=%h len=%0d want %h/%h/%0d",
                   k, obs0[k].op, obs0[k].a, obs0[k].rl, want[k].op, want[k].a, want[k].rl);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    // Output held valid (drdy=1) with an op pending, then reset off-edge.
    ack_in[0] = 1'b0;
    present(0, oh(OP_INC), 8'h10);
    wait_take(0, "ar_take");
    present(0, oh(OP_INC), 8'h10);
    wait_take(0, "ar_take");
    present(0, oh(OP_OUT), 8'h66);
    cycles(1);
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (drdy[0] !== 1'b0 || a_out[0] !== 8'h00 || op_out[0] !== 8'h00 || rl16 !== 5'd0) begin
      n_bad++;
      $display("FAIL ar_clear: got drdy=%0b op=%h a=%h len=%0d want all 0",
               drdy[0], op_out[0], a_out[0], rl16);
    end
    idle(0);
    ack_in[0] = 1'b1;
    #2 reset = 1'b1;
    cycles(1);
    // Reset in the middle of an open run; the partial fold must vanish.
    present(0, oh(OP_INC), 8'h30);
    wait_take(0, "ar_take");
    present(0, oh(OP_INC), 8'h30);
    wait_take(0, "ar_take");
    #3 reset = 1'b0;
    #1 idle(0);
    #2 reset = 1'b1;
    cycles(1);
    obs0.delete();
    present(0, oh(OP_INC), 8'h50);
    wait_take(0, "ar_fresh_take");
    idle(0);
    cycles(3);
    n_cmp++;
    if (obs0.size() != 1) begin
      n_bad++;
      $display("FAIL ar_fresh_count: got %0d outputs want 1", obs0.size());
    end else begin
      n_cmp++;
      if (obs0[0].op !== oh(OP_INC) || obs0[0].a !== 8'h51 || obs0[0].rl != 1) begin
        n_bad++;
        $display("FAIL ar_fresh: got op=%h a=%h len=%0d want %h/51/1",
                 obs0[0].op, obs0[0].a, obs0[0].rl, oh(OP_INC));
      end
    end
  endtask

  task automatic test_random(input int u, input int max_run, input int n);
    int others [4];
    others = '{OP_RIGHT, OP_LEFT, OP_JZ, OP_JNZ};
    src_q.delete();
    for (int k = 0; k < n; k++) begin
      src_t s;
      int   r;
      r = (k < 20) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 9));
      if (r <= 3)      s.op = oh(OP_INC);
      else if (r <= 6) s.op = oh(OP_DEC);
      else if (r == 7) s.op = oh(OP_OUT);
      else if (r == 8) s.op = oh(OP_IN);
      else             s.op = oh(others[$urandom_range(0, 3)]);
      case ($urandom_range(0, 5))
        0:       s.a = 8'h00;
        1:       s.a = 8'hFF;
        default: s.a = 8'($urandom);
      endcase
      s.gap = (k >= 20 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      src_q.push_back(s);
    end
    build_expect(max_run);
    ack_in[u] = 1'b1;
    if (u == 0) obs0.delete(); else obs1.delete();
    foreach (src_q[k]) begin
      if (src_q[k].gap > 0) begin
        idle(u);
        cycles(src_q[k].gap);
      end
      present(u, src_q[k].op, src_q[k].a);
      wait_take(u, "rand_take");
    end
    idle(u);
    cycles(6);
    begin
      out_t got[$];
      got = (u == 0) ? obs0 : obs1;
      n_cmp++;
      if (got.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL rand_count u%0d: got %0d outputs want %0d", u, got.size(), exp_q.size());
      end
      for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
        n_cmp++;
        if (got[k].op !== exp_q[k].op || got[k].a !== exp_q[k].a || got[k].rl != exp_q[k].rl) begin
          n_bad++;
          $display("FAIL rand_out u%0d #%0d: got op=%h a=%h len=%0d want %h/%h/%0d",
                   u, k, got[k].op, got[k].a, got[k].rl, exp_q[k].op, exp_q[k].a, exp_q[k].rl);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      idle(u);
      ack_in[u] = 1'b1;
    end
    #23 reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_pass_through();
    test_fold();
    test_bubble();
    test_run_limit();
    test_backpressure();
    test_async_reset();
    test_random(0, 16, 200);
    test_random(1, 4, 200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_modify_fold.md
Name: stage_modify_fold

Overview:
- Successor to the cell-modify pipeline stage of the BF CPU.
- Parametrised in data width and fold depth.
- Folds back-to-back INC/DEC ops into one cell write: a run of N "+"/"-" costs one downstream write, not N.
- Sits between the cell-read stage and the write-back stage. Uses the same one-hot opcode bus (`OPCODE_MSB, `OP_INC, `OP_DEC, `OP_IN, `OP_OUT) and drdy/ack handshake as the existing stages.

Parameters:
- D_WIDTH, 8, cell/data width in bits.
- MAX_RUN, 16, max source ops folded into one output; legal range 1..255; 1 = no folding.
- RUN_WIDTH, $clog2(MAX_RUN+1), localparam; width of run counter and run_len.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- a_in  in  D_WIDTH  cell value (or input byte for IN) accompanying operation_in.
- operation_in  in  OPCODE_MSB+1  one-hot op from upstream.
- drdy_in  in  1  upstream op valid.
- ack  out  1  upstream op consumed this cycle (combinational).
- a  out  D_WIDTH  value to write back / output.
- operation  out  OPCODE_MSB+1  op presented downstream.
- drdy  out  1  downstream output valid.
- ack_in  in  1  downstream accepts the output.
- run_len  out  RUN_WIDTH  number of source ops folded into the current output.

Behaviour:
- Definitions:
  - fold = operation_in[`OP_INC] | operation_in[`OP_DEC].
  - free = !drdy | ack_in (output slot can load this cycle).
  - take = drdy_in & ack.
- Reset (async, reset==0): state=IDLE; drdy=0; operation=0; a=0; run_len=0; internal val=0, run=0, op0=0. Takes effect immediately, including mid-run; any partial fold is discarded.
- Output holding: output registers hold while drdy & !ack_in. drdy clears on ack_in when no new load happens that cycle.
- IDLE:
  - ack = free.
  - On take with fold: val <= a_in±1 (step rule); run <= 1; op0 <= operation_in; go to ACCUM; no output load.
  - On take with !fold: output loads operation <= operation_in; a <= a_in if OP_IN|OP_OUT, else 0; run_len <= 1; drdy <= 1.
  - If MAX_RUN==1, a fold op goes straight to emit (same as the ACCUM emit case) and no ACCUM cycle occurs.
- ACCUM:
  - ack = drdy_in & fold & (run != MAX_RUN).
  - On take: val steps ±1 per that op's opcode; run++.
  - Emit when free and (!drdy_in or !fold or run==MAX_RUN): operation <= op0; a <= val; run_len <= run; drdy <= 1; go to IDLE.
  - The breaking op is not consumed during the emit cycle; IDLE consumes it on a later cycle.
  - If emit is required but !free, stay in ACCUM with ack=0.
- Step rule (default): val±1 modulo 2^D_WIDTH. Wrap: 255+1 -> 0, 0-1 -> 255.
- Latency:
  - Pass-through op: 1 cycle, take to drdy.
  - Run of N: emitted 1 cycle after the cycle its terminating condition is seen with the slot free.
  - Throughput: 1 output/cycle.
- Mixed runs fold in order ("+","-","+" from 5 gives 6). operation reports the first op of the run.
- drdy_in low in ACCUM flushes immediately; there is no wait-for-more timeout.

Optional Feature:
- Macro: STAGE_MODIFY_SATURATE_EN.
- Defined: the step rule saturates per step. INC at 2^D_WIDTH-1 stays there; DEC at 0 stays 0. Applies to every step, including the first.
- Saturation is applied per step, not to the net value: from max, "+","-" gives max-1.
- Undefined: modular wrap as above. No saturation logic is synthesised.

Decomposition:
- Opcode bit indices and OPCODE_MSB stay in the shared Constants.v.
- Add `FOLD_IDLE / `FOLD_ACCUM state encodings there.
- One natural sub-module: stage_modify_step (combinational val±1 with wrap/saturate selection). It is the only place the macro is tested.

Test Plan:
- Pass-through: OUT with a_in=0x41, ack_in=1 -> next cycle drdy=1, operation=OUT, a=0x41, run_len=1. A "<" op -> a=0.
- Fold: 5×INC back-to-back from a_in=0xFE (wrap build) -> one output a=0x03, operation=INC, run_len=5. Same stimulus with saturate -> a=0xFF.
- Run limit: MAX_RUN=4, 6×DEC from 10 -> outputs a=6 (run_len=4), then a=8 (run_len=2).
- Backpressure: ack_in=0 during a 3-INC run followed by OUT -> ACCUM holds with ack=0 on OUT; after ack_in rises, INC output precedes OUT output, nothing lost or duplicated.
- Bubble flush: INC, INC, drdy_in=0 -> emits run_len=2 the cycle after the bubble.
- Async reset: reset=0 mid-run while drdy=1, asserted off a clock edge -> drdy, a, operation, run_len are 0 before the next edge. First op after release starts a fresh run.
